// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host command path: FSM states,
// well-known mouse command bytes, completion codes and default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_REQUEST,
    ST_SHIFT,
    ST_ACK,
    ST_RELEASE
  } ps2_state_e;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  localparam logic [1:0] ERR_ACKED   = 2'b00;
  localparam logic [1:0] ERR_NO_ACK  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // slow_clock is about 97.66 kHz, so 12 cycles is just over 100 us
  // and 1500 cycles is roughly 15.4 ms.
  localparam int INHIBIT_CYCLES_DEFAULT = 12;
  localparam int TIMEOUT_CYCLES_DEFAULT = 1500;

  // PS/2 frames carry odd parity over the eight data bits.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_cmd_tx_if.sv
// Command handshake between a controller and the PS/2 command transmitter.
interface ps2_cmd_tx_if;

  logic       cmd_valid;
  logic [7:0] cmd_byte;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic [1:0] err;

  modport master (
    output cmd_valid, cmd_byte,
    input  cmd_ready, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_byte,
    output cmd_ready, busy, done, err
  );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for a PS/2 pad with a history flop for falling-edge
// detection. All flops reset to 1 because an idle PS/2 line floats high.
module ps2_sync_edge (
  input  logic slow_clock,
  input  logic reset,
  input  logic pad_in,
  output logic level,
  output logic fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic hist_q, hist_d;

  // Shift the pad level one stage per cycle down the chain.
  always_comb begin
    meta_d = pad_in;
    sync_d = meta_q;
    hist_d = sync_q;
  end

  // Chain registers; an idle line reads high out of reset.
  always_ff @(posedge slow_clock or negedge reset) begin
    if (!reset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      hist_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign level = sync_q;
  assign fall  = hist_q & ~sync_q;

endmodule

// File: rtl/ps2_cmd_tx.sv
// Host-to-device PS/2 command transmitter: request-to-send, 11-bit host
// frame clocked by the device, acknowledge check and line release wait.
module ps2_cmd_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEFAULT,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        slow_clock,
  input  logic        reset,
  ps2_cmd_tx_if.slave cmd,
  input  logic        ps2_clk_in,
  input  logic        ps2_dat_in,
  output logic        ps2_clk_oe,
  output logic        ps2_dat_oe
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_e       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             parity_q, parity_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             clk_oe_q, clk_oe_d;
  logic             dat_oe_q, dat_oe_d;
  logic             done_q, done_d;
  logic [1:0]       err_q, err_d;

  logic clk_level, clk_fall;
  logic dat_level, dat_fall_unused;
  logic tx_bit;

  ps2_sync_edge u_clk_sync (
    .slow_clock (slow_clock),
    .reset      (reset),
    .pad_in     (ps2_clk_in),
    .level      (clk_level),
    .fall       (clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .slow_clock (slow_clock),
    .reset      (reset),
    .pad_in     (ps2_dat_in),
    .level      (dat_level),
    .fall       (dat_fall_unused)
  );

  // Select the frame bit for the current position: data LSB first, parity, stop.
  always_comb begin
    tx_bit = 1'b1;
    if (bit_cnt_q < 4'd8) begin
      tx_bit = byte_q[bit_cnt_q[2:0]];
    end else if (bit_cnt_q == 4'd8) begin
      tx_bit = parity_q;
    end
  end

  // Next-state and output logic; the done cycle always hands back to IDLE.
  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    parity_d  = parity_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    to_cnt_d  = to_cnt_q;
    clk_oe_d  = clk_oe_q;
    dat_oe_d  = dat_oe_q;
    err_d     = err_q;
    done_d    = 1'b0;

    if (done_q) begin
      state_d  = ST_IDLE;
      clk_oe_d = 1'b0;
      dat_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          if (cmd.cmd_valid) begin
            byte_d    = cmd.cmd_byte;
            parity_d  = odd_parity(cmd.cmd_byte);
            bit_cnt_d = '0;
            inh_cnt_d = '0;
            to_cnt_d  = '0;
            err_d     = ERR_ACKED;
            clk_oe_d  = 1'b1;
            state_d   = ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
            dat_oe_d = 1'b1;
            state_d  = ST_REQUEST;
          end else begin
            inh_cnt_d = inh_cnt_q + 1'b1;
          end
        end
        ST_REQUEST: begin
          clk_oe_d = 1'b0;
          to_cnt_d = '0;
          state_d  = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (clk_fall) begin
            dat_oe_d  = ~tx_bit;
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 4'd9) begin
              state_d = ST_ACK;
            end
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            err_d   = dat_level ? ERR_NO_ACK : ERR_ACKED;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (clk_level && dat_level) begin
            done_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase

      if (state_q == ST_SHIFT || state_q == ST_ACK || state_q == ST_RELEASE) begin
        if (clk_fall) begin
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          err_d    = ERR_TIMEOUT;
          done_d   = 1'b1;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
    end
  end

  // State and datapath registers; reset releases both pads at once.
  always_ff @(posedge slow_clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      byte_q    <= '0;
      parity_q  <= 1'b0;
      bit_cnt_q <= '0;
      inh_cnt_q <= '0;
      to_cnt_q  <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_ACKED;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      parity_q  <= parity_d;
      bit_cnt_q <= bit_cnt_d;
      inh_cnt_q <= inh_cnt_d;
      to_cnt_q  <= to_cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign ps2_clk_oe    = clk_oe_q;
  assign ps2_dat_oe    = dat_oe_q;
  assign cmd.cmd_ready = (state_q == ST_IDLE);
  assign cmd.busy      = (state_q != ST_IDLE);
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;

endmodule

// File: tb/tb_ps2_cmd_tx.sv
// Self-checking bench for ps2_cmd_tx with a simple PS/2 device model that
// clocks at about 12.5 kHz (4 slow_clock cycles low, 4 high).
module tb_ps2_cmd_tx;
  import ps2_pkg::*;

  logic slow_clock = 1'b0;
  logic reset;
  logic dev_clk;
  logic dev_dat;
  logic ps2_clk_oe;
  logic ps2_dat_oe;
  logic clk_pad;
  logic dat_pad;

  int checks   = 0;
  int failures = 0;

  localparam int MODE_ACK     = 0;
  localparam int MODE_NO_ACK  = 1;
  localparam int MODE_SILENT  = 2;
  localparam int MODE_PARTIAL = 3;

  typedef struct {
    logic [7:0]  cmd;
    int          mode;
    logic [10:0] frame;
    logic [1:0]  err;
  } vec_t;

  vec_t vecs [5];

  assign clk_pad = ~ps2_clk_oe & dev_clk;
  assign dat_pad = ~ps2_dat_oe & dev_dat;

  ps2_cmd_tx_if cmd_if ();

  ps2_cmd_tx dut (
    .slow_clock (slow_clock),
    .reset      (reset),
    .cmd        (cmd_if),
    .ps2_clk_in (clk_pad),
    .ps2_dat_in (dat_pad),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one command for a single cycle; returns at the cycle after acceptance.
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    while (!cmd_if.cmd_ready && n < 40) begin
      n++;
      step();
    end
    checkOutput("ready before cmd", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_byte  = b;
    step();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_byte  = 8'h5A;
  endtask

  // Follow one transaction from the cycle after acceptance, playing the device.
  task automatic runFrame(input int mode, input logic [10:0] exp_frame, input logic [1:0] exp_err);
    int inh;
    int req;
    int n;
    logic [10:0] seen;
    seen = '0;
    checkOutput("ready low after accept", 32'(cmd_if.cmd_ready), 32'd0);
    checkOutput("clk_oe after accept", 32'(ps2_clk_oe), 32'd1);
    inh = 0;
    while (ps2_clk_oe && !ps2_dat_oe && inh < 40) begin
      inh++;
      step();
    end
    checkOutput("inhibit length", 32'(inh), 32'd12);
    req = 0;
    while (ps2_clk_oe && ps2_dat_oe && req < 40) begin
      req++;
      step();
    end
    checkOutput("request length", 32'(req), 32'd1);
    checkOutput("oe after request", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b01);

    if (mode == MODE_SILENT) begin
      n = 0;
      while (!cmd_if.done && n < 1600) begin
        n++;
        step();
      end
      checkOutput("timeout cycles", 32'(n), 32'd1500);
      checkOutput("timeout done", 32'(cmd_if.done), 32'd1);
      checkOutput("timeout err", 32'(cmd_if.err), 32'(ERR_TIMEOUT));
      checkOutput("timeout oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
      step();
      checkOutput("timeout ready next", 32'(cmd_if.cmd_ready), 32'd1);
      checkOutput("timeout done gone", 32'(cmd_if.done), 32'd0);
    end else begin
      seen[0] = dat_pad;
      repeat (4) step();
      for (int i = 1; i <= 10; i++) begin
        if (!(mode == MODE_PARTIAL && i > 5)) begin
          dev_clk = 1'b0;
          repeat (4) step();
          dev_clk = 1'b1;
          seen[i] = dat_pad;
          repeat (4) step();
        end
      end
      if (mode != MODE_PARTIAL) begin
        checkOutput("frame bits", 32'(seen), 32'(exp_frame));
        if (mode == MODE_ACK) dev_dat = 1'b0;
        dev_clk = 1'b0;
        repeat (4) step();
        dev_clk = 1'b1;
        step();
        dev_dat = 1'b1;
        n = 0;
        while (!cmd_if.done && n < 40) begin
          n++;
          step();
        end
        checkOutput("done pulse", 32'(cmd_if.done), 32'd1);
        checkOutput("done err", 32'(cmd_if.err), 32'(exp_err));
        checkOutput("done oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
        checkOutput("busy at done", 32'(cmd_if.busy), 32'd1);
        checkOutput("ready at done", 32'(cmd_if.cmd_ready), 32'd0);
        step();
        checkOutput("ready after done", 32'(cmd_if.cmd_ready), 32'd1);
        checkOutput("done one cycle", 32'(cmd_if.done), 32'd0);
        checkOutput("busy after done", 32'(cmd_if.busy), 32'd0);
        checkOutput("oe after done", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Frames are {stop, parity, d7..d0, start}, hand-computed.
    vecs[0] = '{CMD_ENABLE,   MODE_ACK,    11'h5E8, ERR_ACKED};
    vecs[1] = '{8'h00,        MODE_ACK,    11'h600, ERR_ACKED};
    vecs[2] = '{CMD_RESET,    MODE_ACK,    11'h7FE, ERR_ACKED};
    vecs[3] = '{CMD_SET_RATE, MODE_ACK,    11'h7E6, ERR_ACKED};
    vecs[4] = '{CMD_ENABLE,   MODE_NO_ACK, 11'h5E8, ERR_NO_ACK};

    reset            = 1'b0;
    dev_clk          = 1'b1;
    dev_dat          = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_byte  = 8'h00;
    repeat (3) step();
    checkOutput("reset oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
    checkOutput("reset ready", 32'(cmd_if.cmd_ready), 32'd1);
    checkOutput("reset busy", 32'(cmd_if.busy), 32'd0);
    checkOutput("reset done", 32'(cmd_if.done), 32'd0);
    checkOutput("reset err", 32'(cmd_if.err), 32'd0);
    reset = 1'b1;
    repeat (2) step();

    $display("[TB] table-driven frames");
    for (int v = 0; v < 5; v++) begin
      applyStimulus(vecs[v].cmd);
      runFrame(vecs[v].mode, vecs[v].frame, vecs[v].err);
      repeat (3) step();
    end

    $display("[TB] silent device timeout");
    applyStimulus(CMD_ENABLE);
    runFrame(MODE_SILENT, 11'h000, ERR_TIMEOUT);
    repeat (3) step();

    $display("[TB] reset in the middle of SHIFT");
    applyStimulus(8'h00);
    runFrame(MODE_PARTIAL, 11'h000, ERR_ACKED);
    checkOutput("dat_oe before reset", 32'(ps2_dat_oe), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid reset oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b00);
    checkOutput("mid reset ready", 32'(cmd_if.cmd_ready), 32'd1);
    checkOutput("mid reset busy", 32'(cmd_if.busy), 32'd0);
    repeat (3) step();
    reset = 1'b1;
    repeat (2) step();
    applyStimulus(CMD_RESET);
    runFrame(MODE_ACK, 11'h7FE, ERR_ACKED);
    repeat (3) step();

    $display("[TB] cmd_valid held with a changing byte");
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_byte  = CMD_ENABLE;
    step();
    cmd_if.cmd_byte = 8'h00;
    runFrame(MODE_ACK, 11'h5E8, ERR_ACKED);
    step();
    cmd_if.cmd_valid = 1'b0;
    runFrame(MODE_ACK, 11'h600, ERR_ACKED);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_cmd_tx.md
# ps2_cmd_tx

Host-to-device PS/2 command transmitter for the mouse interface: accepts one command byte (e.g. 0xF4 enable reporting, 0xFF reset) and drives the PS/2 request-to-send sequence, the 11-bit host frame and the device acknowledge check. It runs on the divided `slow_clock` (50 MHz / 512 ≈ 97.66 kHz, 10.24 µs period) and sits beside the mouse receive path. It drives the shared open-drain `PS2_CLK` / `PS2_DAT` pads through pull-low enables; the top level owns the tristate buffers. While it is busy, the receive path is inhibited.

## Interface
- `INHIBIT_CYCLES`, 12: cycles CLK is held low before the start bit (≥100 µs; 12 × 10.24 = 122.9 µs).
- `TIMEOUT_CYCLES`, 1500: maximum cycles allowed without progress (≈15.4 ms) before abort.
- `slow_clock`  in  1  block clock.
- `reset`  in  1  asynchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_byte`  in  8  command to send.
- `cmd_ready`  out  1  high only in IDLE.
- `ps2_clk_in`  in  1  raw CLK pad level.
- `ps2_dat_in`  in  1  raw DAT pad level.
- `ps2_clk_oe`  out  1  1 = pull CLK low.
- `ps2_dat_oe`  out  1  1 = pull DAT low.
- `busy`  out  1  high in any non-IDLE state; gates the receiver.
- `done`  out  1  one-cycle pulse at the end of a transaction.
- `err`  out  2  valid with `done`: 00 = acked, 01 = no ack (DAT high at ack edge), 10 = timeout.

## Operation
- States: IDLE, INHIBIT, REQUEST, SHIFT, ACK, RELEASE.
- IDLE: both `oe` are 0. When `cmd_valid & cmd_ready`, latch `cmd_byte`, compute odd parity `~^cmd_byte`, clear counters, go to INHIBIT.
- INHIBIT: `ps2_clk_oe`=1 for exactly `INHIBIT_CYCLES` cycles, then go to REQUEST.
- REQUEST: one cycle with both `oe` = 1 (start bit 0), then go to SHIFT with `ps2_clk_oe`=0 and `ps2_dat_oe` still 1.
- SHIFT: on each synchronized CLK falling edge, present the next bit, with `ps2_dat_oe = ~bit`. Order: d0..d7 (LSB first), parity, stop (1 = release). The 4-bit bit counter runs 0..9. The edge that presents the stop bit moves the FSM to ACK.
- ACK: on the next falling edge, sample synchronized DAT. 0 records `err`=00; 1 records `err`=01. Then go to RELEASE.
- RELEASE: wait until synchronized CLK and DAT are both 1. Then pulse `done` with the recorded `err` and go to IDLE.
- Timeout: a counter runs in SHIFT, ACK and RELEASE and clears on every detected falling edge. When it reaches `TIMEOUT_CYCLES`, both `oe` go to 0, `done` pulses with `err`=10, and the FSM goes to IDLE.
- `cmd_valid` outside IDLE is ignored; no queuing.
- Reset at any point: both `oe` go to 0 immediately and the FSM enters IDLE. The device sees the lines released and aborts the frame itself.

## Timing
- Reset values: state IDLE, `ps2_clk_oe`=0, `ps2_dat_oe`=0, `cmd_ready`=1, `busy`=0, `done`=0, `err`=00; synchronizer flops are reset to 1.
- Acceptance cycle N: `cmd_ready`=0 and `ps2_clk_oe`=1 from N+1.
- REQUEST occupies cycle N+1+INHIBIT_CYCLES. CLK is released at the following cycle.
- CLK sampling: two-flop synchronizer plus one history flop. A falling edge is detected 2 cycles after the pad falls, and DAT is updated on the next edge.
- Pad-fall to DAT change is ≤3 cycles (≤30.7 µs), inside the device's clock-low phase.
- DAT sampling for ack uses its own two-flop synchronizer, read in the cycle the falling edge is detected.
- `done` is high for exactly one cycle; `cmd_ready` is high in the same cycle as `done`'s following cycle (IDLE).
- Outputs are registered, with no combinational path from pads to `oe`.

## Structure
- Shared `ps2_pkg` holds:
  - the state enum;
  - constants `CMD_RESET` 8'hFF, `CMD_ENABLE` 8'hF4, `CMD_SET_RATE` 8'hF3, `ACK_BYTE` 8'hFA;
  - `err` codes;
  - default `INHIBIT_CYCLES` / `TIMEOUT_CYCLES`.
- Sub-module `ps2_sync_edge`: 2-flop synchronizer with a history flop, reset-to-1, and a `fall` output. It is instantiated for CLK; DAT uses the same module with `fall` unused.

## Test plan
- Send 0xF4 with a device model clocking at 12.5 kHz → `ps2_clk_oe` held 12 cycles, then a 1-cycle REQUEST. DAT bits seen at rising edges: 0 (start), 0,0,1,0,1,1,1,1, parity 0, stop 1. Model acks low → `done` pulse with `err`=00.
- Send 0x00 → parity bit 1; send 0xFF → parity bit 1. Both complete with `err`=00.
- Model never pulls DAT at the 11th edge → `done` with `err`=01, and both `oe`=0 afterwards.
- Model never clocks after REQUEST → after 1500 cycles in SHIFT, `done` with `err`=10, both `oe`=0, `cmd_ready`=1 on the next cycle.
- Assert `reset` low mid-SHIFT (after bit 4) → `ps2_dat_oe`=0 and `ps2_clk_oe`=0 immediately. Release reset and send 0xFF → a clean full frame.
- Hold `cmd_valid` high with a changing `cmd_byte` during a transaction → only the originally latched byte is sent, and the second command is accepted only after `done`.
